// File: rtl/waveshaper_pkg.sv
// waveshaper_pkg
//   Shared types and elaboration-time helpers for the waveshaper:
//   - mode_e      : per-sample shaping mode (encoding 2'b11 decodes as soft)
//   - frac_w()    : interpolation fraction width from sample and index widths
//   - saturate()  : clamp a wide signed value into [lo, hi]
//   - curve_point(): one entry of the normalised tanh soft-clip table
package waveshaper_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_SOFT   = 2'b01,
        MODE_HARD   = 2'b10
    } mode_e;

    function automatic int frac_w(input int data_w, input int addr_w);
        return data_w - addr_w;
    endfunction

    function automatic longint saturate(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // tanh for a >= 0 built from a power series of exp(2a)-1, so it can be
    // folded at elaboration without relying on tool math built-ins. Keeping
    // exp(2a)-1 separate avoids cancellation for small arguments.
    function automatic real tanh_pos(input real a);
        real term;
        real em1;
        term = 1.0;
        em1  = 0.0;
        for (int n = 1; n <= 80; n++) begin
            term = term * (2.0 * a) / n;
            em1  = em1 + term;
        end
        return em1 / (em1 + 2.0);
    endfunction

    // The positive half is rounded (half up) and the negative half is its
    // exact negation, so the table is bit-exactly odd-symmetric and both
    // endpoints land on +/- full scale.
    function automatic int curve_point(input int i, input int data_w,
                                       input int addr_w, input real k);
        int  half;
        int  full;
        int  m;
        int  pos;
        real r;
        half = 1 << (addr_w - 1);
        full = (1 << (data_w - 1)) - 1;
        m    = (i >= half) ? (i - half) : (half - i);
        if (m == half) begin
            pos = full;
        end else begin
            r   = full * tanh_pos(k * m / half) / tanh_pos(k);
            pos = $rtoi(r + 0.5);
        end
        return (i >= half) ? pos : -pos;
    endfunction

endpackage

// File: rtl/softclip_curve_rom.sv
// softclip_curve_rom
//   Combinational dual-read tanh table with 2^ADDR_W+1 points generated at
//   elaboration.
//   idx  : table index 0 .. 2^ADDR_W-1
//   t_lo : T[idx]
//   t_hi : T[idx+1]; idx = 2^ADDR_W-1 reads the top endpoint (no wrap)
module softclip_curve_rom
    import waveshaper_pkg::*;
#(
    parameter int  DATA_W  = 16,
    parameter int  ADDR_W  = 8,
    parameter real CURVE_K = 3.0
) (
    input  logic        [ADDR_W-1:0] idx,
    output logic signed [DATA_W-1:0] t_lo,
    output logic signed [DATA_W-1:0] t_hi
);

    localparam int N = (1 << ADDR_W) + 1;

    logic signed [DATA_W-1:0] tbl [0:N-1];

    for (genvar i = 0; i < N; i++) begin : g_tbl
        localparam int P = curve_point(i, DATA_W, ADDR_W, CURVE_K);
        assign tbl[i] = DATA_W'(P);
    end

    // One extra index bit so idx+1 can address the endpoint beyond 2^ADDR_W-1.
    logic [ADDR_W:0] idx_lo;
    logic [ADDR_W:0] idx_hi;

    assign idx_lo = {1'b0, idx};
    assign idx_hi = idx_lo + (ADDR_W + 1)'(1);
    assign t_lo   = tbl[idx_lo];
    assign t_hi   = tbl[idx_hi];

endmodule

// File: rtl/waveshaper_interp.sv
// waveshaper_interp
//   Pipelined waveshaper: drive (pre-gain with saturation), then per-sample
//   bypass / tanh soft clip with linear interpolation / hard clip.
//   Ports:
//     clk, rst         : clock, synchronous active-high reset
//     in_sample        : signed input sample
//     in_valid/ready   : input stream handshake
//     mode             : 00 bypass, 01 soft, 10 hard, 11 soft (per sample)
//     gain_shift       : left shift 0..7 applied with saturation (per sample)
//     hard_thresh      : positive clip level for hard mode (per sample)
//     out_sample       : shaped sample
//     out_valid/ready  : output stream handshake
//   Handshake: a transfer happens on a clock edge where valid && ready. The
//   whole pipeline advances when the output register is empty or being
//   drained (advance = !out_valid || out_ready), and in_ready = advance; when
//   it does not advance every stage, out_sample and out_valid hold. Empty
//   slots travel through the pipe as bubbles. A sample accepted at edge N is
//   presented after edge N+3.
module waveshaper_interp
    import waveshaper_pkg::*;
#(
    parameter int  DATA_W  = 16,
    parameter int  ADDR_W  = 8,
    parameter real CURVE_K = 3.0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic        [1:0]        mode,
    input  logic        [2:0]        gain_shift,
    input  logic        [DATA_W-2:0] hard_thresh,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int     FRAC_W = frac_w(DATA_W, ADDR_W);
    localparam int     XW     = DATA_W + 7;
    localparam int     PW     = DATA_W + 1 + FRAC_W;
    localparam longint SMAX   = (longint'(1) << (DATA_W - 1)) - 1;
    localparam longint SMIN   = -(longint'(1) << (DATA_W - 1));

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1: drive
    logic signed [XW-1:0]     x_wide;
    logic signed [DATA_W-1:0] x_sat;
    assign x_wide = XW'(in_sample) <<< gain_shift;
    assign x_sat  = DATA_W'(saturate(longint'(x_wide), SMIN, SMAX));

    logic                     s1_valid;
    logic signed [DATA_W-1:0] s1_x;
    logic signed [DATA_W-1:0] s1_raw;
    logic        [1:0]        s1_mode;
    logic        [DATA_W-2:0] s1_thresh;

    // Stage 2: lookup. Adding 2^(DATA_W-1) to x only flips its sign bit.
    logic        [ADDR_W-1:0] idx;
    logic        [FRAC_W-1:0] frac;
    logic signed [DATA_W-1:0] t_lo;
    logic signed [DATA_W-1:0] t_hi;
    logic signed [DATA_W-1:0] thr;
    logic signed [DATA_W-1:0] x_clamp;

    assign idx  = {~s1_x[DATA_W-1], s1_x[DATA_W-2:FRAC_W]};
    assign frac = s1_x[FRAC_W-1:0];
    assign thr  = $signed({1'b0, s1_thresh});

    softclip_curve_rom #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CURVE_K(CURVE_K)
    ) u_rom (
        .idx (idx),
        .t_lo(t_lo),
        .t_hi(t_hi)
    );

    always_comb begin
        x_clamp = s1_x;
        if (s1_x > thr) begin
            x_clamp = thr;
        end else if (s1_x < -thr) begin
            x_clamp = -thr;
        end
    end

    logic                     s2_valid;
    logic signed [DATA_W-1:0] s2_t_lo;
    logic signed [DATA_W-1:0] s2_t_hi;
    logic        [FRAC_W-1:0] s2_frac;
    logic signed [DATA_W-1:0] s2_raw;
    logic signed [DATA_W-1:0] s2_clamp;
    logic        [1:0]        s2_mode;

    // Stage 3: interpolate (slope times fraction, full precision)
    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   prod;
    assign diff = (DATA_W + 1)'(s2_t_hi) - (DATA_W + 1)'(s2_t_lo);
    assign prod = PW'(diff) * PW'($signed({1'b0, s2_frac}));

    logic                     s3_valid;
    logic signed [PW-1:0]     s3_prod;
    logic signed [DATA_W-1:0] s3_t_lo;
    logic signed [DATA_W-1:0] s3_raw;
    logic signed [DATA_W-1:0] s3_clamp;
    logic        [1:0]        s3_mode;

    // Output: finish the interpolation (floor shift; result never exceeds
    // the table range so no saturation) and select by mode.
    logic signed [DATA_W-1:0] y;
    logic signed [DATA_W-1:0] out_next;
    assign y = s3_t_lo + DATA_W'(s3_prod >>> FRAC_W);

    always_comb begin
        out_next = y;
        if (s3_mode == MODE_BYPASS) begin
            out_next = s3_raw;
        end else if (s3_mode == MODE_HARD) begin
            out_next = s3_clamp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_x       <= '0;
            s1_raw     <= '0;
            s1_mode    <= '0;
            s1_thresh  <= '0;
            s2_valid   <= 1'b0;
            s2_t_lo    <= '0;
            s2_t_hi    <= '0;
            s2_frac    <= '0;
            s2_raw     <= '0;
            s2_clamp   <= '0;
            s2_mode    <= '0;
            s3_valid   <= 1'b0;
            s3_prod    <= '0;
            s3_t_lo    <= '0;
            s3_raw     <= '0;
            s3_clamp   <= '0;
            s3_mode    <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_x      <= x_sat;
            s1_raw    <= in_sample;
            s1_mode   <= mode;
            s1_thresh <= hard_thresh;

            s2_valid  <= s1_valid;
            s2_t_lo   <= t_lo;
            s2_t_hi   <= t_hi;
            s2_frac   <= frac;
            s2_raw    <= s1_raw;
            s2_clamp  <= x_clamp;
            s2_mode   <= s1_mode;

            s3_valid  <= s2_valid;
            s3_prod   <= prod;
            s3_t_lo   <= s2_t_lo;
            s3_raw    <= s2_raw;
            s3_clamp  <= s2_clamp;
            s3_mode   <= s2_mode;

            out_valid <= s3_valid;
            // A bubble leaves the last presented value in place.
            if (s3_valid) begin
                out_sample <= out_next;
            end
        end
    end

endmodule

// File: tb/tb_waveshaper_interp.sv
module tb_waveshaper_interp;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [W-1:0] in_sample = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic        [1:0]   mode = 2'b01;
    logic        [2:0]   gain_shift = '0;
    logic        [W-2:0] hard_thresh = '0;
    logic signed [W-1:0] out_sample;
    logic                out_valid;
    logic                out_ready = 1'b1;

    always #5 clk = ~clk;

    waveshaper_interp #(
        .DATA_W (16),
        .ADDR_W (8),
        .CURVE_K(3.0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .gain_shift (gain_shift),
        .hard_thresh(hard_thresh),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // ---------------- scoreboard state ----------------
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    time          lat_q[$];
    int           act_log[$];
    bit           lat_en = 1'b0;
    bit           log_en = 1'b0;
    bit           tog_en = 1'b0;
    int           ref_tbl[0:256];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model straight from the shaping rules, plain integer math.
    function automatic int model(input logic [1:0] m, input int g, input int thr, input int s);
        longint x;
        int     u;
        int     idx;
        int     frac;
        int     p;
        int     q;
        if (m == 2'b00) return s;
        x = longint'(s) * (longint'(1) << g);
        if (x > 32767) x = 32767;
        if (x < -32768) x = -32768;
        if (m == 2'b10) begin
            if (x > thr) return thr;
            if (x < -thr) return -thr;
            return int'(x);
        end
        u    = int'(x) + 32768;
        idx  = u / 256;
        frac = u % 256;
        p    = (ref_tbl[idx + 1] - ref_tbl[idx]) * frac;
        q    = (p >= 0) ? (p / 256) : -((-p + 255) / 256);
        return ref_tbl[idx] + q;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        string        nm;
        time          t;
        if (!rst && out_valid && out_ready) begin
            if (log_en) act_log.push_back(int'(out_sample));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d expected none", out_sample);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                t  = lat_q.pop_front();
                check(nm, int'(out_sample), int'($signed(e)));
                if (lat_en) check({nm, "_latency"}, int'($time - t), 35);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input string nm, input logic [1:0] m, input int g,
                        input int thr, input int s, input int e);
        int waited;
        bit rdy;
        waited      = 0;
        rdy         = 1'b0;
        mode        = m;
        gain_shift  = 3'(g);
        hard_thresh = 15'(thr);
        in_sample   = 16'(s);
        in_valid    = 1'b1;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout %s: got no ready expected ready", nm);
                break;
            end
        end
        if (rdy) begin
            exp_q.push_back(W'(e));
            name_q.push_back(nm);
            lat_q.push_back($time);
        end
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited;
        waited   = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic flush_sb();
        exp_q.delete();
        name_q.delete();
        lat_q.delete();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        string      name;
        logic [1:0] m;
        int         g;
        int         thr;
        int         s;
        int         e;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string nm, input logic [1:0] m, input int g,
                           input int thr, input int s, input int e);
        vec_t v;
        v.name = nm; v.m = m; v.g = g; v.thr = thr; v.s = s; v.e = e;
        vecs.push_back(v);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        real r;
        logic signed [W-1:0] hold_s;
        logic                hold_v;
        int                  a;
        int                  b;
        int                  s;
        int                  m;
        int                  g;
        int                  thr;

        for (int i = 128; i <= 256; i++) begin
            r = 32767.0 * $tanh(3.0 * (i - 128) / 128.0) / $tanh(3.0);
            ref_tbl[i] = $rtoi(r + 0.5);
        end
        for (int i = 0; i < 128; i++) ref_tbl[i] = -ref_tbl[256 - i];

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_sample", int'(out_sample), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed table, back-to-back, no stall, latency checked
        add_vec("soft_0",        2'b01, 0, 0,     0,      0);
        add_vec("soft_256",      2'b01, 0, 0,     256,    772);
        add_vec("soft_128",      2'b01, 0, 0,     128,    386);
        add_vec("soft_m256",     2'b01, 0, 0,     -256,   -772);
        add_vec("soft_min",      2'b01, 0, 0,     -32768, -32767);
        add_vec("soft_max",      2'b01, 0, 0,     32767,  32766);
        add_vec("soft_idx255",   2'b01, 0, 0,     32640,  32763);
        add_vec("drive2_sat",    2'b01, 2, 0,     8192,   32766);
        add_vec("drive7_neg",    2'b01, 7, 0,     -300,   -32767);
        add_vec("hard_pos",      2'b10, 0, 10000, 20000,  10000);
        add_vec("hard_neg",      2'b10, 0, 10000, -20000, -10000);
        add_vec("hard_pass",     2'b10, 0, 10000, 5000,   5000);
        add_vec("hard_thr0",     2'b10, 0, 0,     1234,   0);
        add_vec("hard_thr0_neg", 2'b10, 0, 0,     -1234,  0);
        add_vec("bypass_g7",     2'b00, 7, 0,     1234,   1234);
        add_vec("bypass_min",    2'b00, 3, 0,     -32768, -32768);
        add_vec("mode11_256",    2'b11, 0, 0,     256,    772);
        lat_en = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].name, vecs[i].m, vecs[i].g, vecs[i].thr, vecs[i].s, vecs[i].e);
        end
        drain();
        lat_en = 1'b0;

        // Backpressure with per-sample modes: 4-cycle stall mid-stream
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    m   = i % 3;
                    g   = $urandom_range(0, 2);
                    thr = $urandom_range(0, 32767);
                    s   = int'($urandom_range(0, 65535)) - 32768;
                    send($sformatf("bp_%0d", i), 2'(m), g, thr, s, model(2'(m), g, thr, s));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                hold_s = out_sample;
                hold_v = out_valid;
                check("stall_out_valid", int'(hold_v), 1);
                check("stall_in_ready", int'(in_ready), 0);
                repeat (3) begin
                    @(negedge clk);
                    check("stall_hold_sample", int'(out_sample), int'(hold_s));
                    check("stall_hold_valid", int'(out_valid), int'(hold_v));
                    check("stall_in_ready", int'(in_ready), 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three samples in flight
        send("rst_a", 2'b01, 0, 0, 1000, 0);
        send("rst_b", 2'b10, 0, 50, 1000, 0);
        send("rst_c", 2'b00, 0, 0, 1000, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        flush_sb();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_sample", int'(out_sample), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        repeat (5) begin
            @(negedge clk);
            check("midrst_no_output", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;

        // Randomised mixed traffic with random downstream stalls
        tog_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    m   = $urandom_range(0, 3);
                    g   = $urandom_range(0, 7);
                    thr = $urandom_range(0, 32767);
                    s   = int'($urandom_range(0, 65535)) - 32768;
                    send("rand", 2'(m), g, thr, s, model(2'(m), g, thr, s));
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                in_valid = 1'b0;
                tog_en   = 1'b0;
            end
            begin
                while (tog_en) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Full soft-mode sweep, then odd symmetry at table points
        log_en = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            s = i - 32768;
            send("sweep", 2'b01, 0, 0, s, model(2'b01, 0, 0, s));
        end
        drain();
        log_en = 1'b0;
        check("sweep_count", act_log.size(), 65536);
        if (act_log.size() == 65536) begin
            for (int k = 1; k < 256; k++) begin
                a = act_log[k * 256];
                b = act_log[(256 - k) * 256];
                check($sformatf("symmetry_%0d", k * 256 - 32768), a, -b);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/waveshaper_interp.md
Name: waveshaper_interp

Overview:
- Parametrised, pipelined successor to the combinational soft-clip table in the distortion path.
- Per-sample selectable mode: bypass, tanh soft clip with linear interpolation between table points, or hard clip at a programmable threshold.
- Programmable pre-gain (drive).
- Sits between the input gain stage and the tone/output stage, with a valid/ready stream on both sides.

Parameters:
DATA_W, 16, sample width, signed two's complement
ADDR_W, 8, table index width; table holds 2^ADDR_W+1 points
CURVE_K, 3, tanh steepness used to generate the table (elaboration-time real)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_sample  in  DATA_W  signed input sample
in_valid  in  1  input sample valid
in_ready  out  1  block can accept the input this cycle
mode  in  2  00 bypass, 01 soft, 10 hard, 11 treated as soft; sampled with in_sample
gain_shift  in  3  drive: input is left-shifted 0..7 with saturation; sampled with in_sample
hard_thresh  in  DATA_W-1  positive clip level for hard mode; sampled with in_sample
out_sample  out  DATA_W  signed shaped sample
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts the output

Behaviour:
- Reset is synchronous, clk only. All stage valids clear to 0 and out_sample resets to 0. in_ready is 1 after reset.
- Reset mid-stream discards all in-flight samples. No output is produced for them.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - A transfer occurs when valid && ready.
  - All three stages shift together only on advance. When advance=0 every stage holds, and out_sample and out_valid stay stable.
  - Bubbles are not compressed.
- Latency: exactly 3 cycles. A sample accepted at edge N is presented with out_valid=1 after edge N+3, with no stall.
- Stage 1 (drive):
  - x = in_sample <<< gain_shift, computed at DATA_W+7 bits.
  - Saturate to [-(2^(DATA_W-1)), 2^(DATA_W-1)-1].
  - Register x, mode, hard_thresh and the raw in_sample.
- Stage 2 (lookup):
  - u = x + 2^(DATA_W-1) (unsigned); idx = u[DATA_W-1:FRAC_W]; frac = u[FRAC_W-1:0], where FRAC_W = DATA_W-ADDR_W.
  - Read T[idx] and T[idx+1] and register both, plus frac.
  - Hard mode: clamp x to [-hard_thresh, +hard_thresh].
- Stage 3 (interpolate):
  - y = T[idx] + ((T[idx+1]-T[idx]) * frac) >>> FRAC_W.
  - The difference is a DATA_W+1-bit signed value. The product is DATA_W+1+FRAC_W signed. The shift is arithmetic (floor).
  - The result always lies within [-(2^(DATA_W-1)-1), 2^(DATA_W-1)-1], so no extra saturation is required.
- Output mux: bypass outputs the raw in_sample (no drive); hard outputs the clamped x; soft/11 outputs y. Registered into out_sample.
- Table:
  - T[i] = round((2^(DATA_W-1)-1) * tanh(CURVE_K*v)/tanh(CURVE_K)), with v = (i - 2^(ADDR_W-1))/2^(ADDR_W-1), for i = 0..2^ADDR_W.
  - Endpoints are exactly ±(2^(DATA_W-1)-1). T[2^(ADDR_W-1)] = 0.
  - Odd symmetry T[i] = -T[2^ADDR_W - i] must hold bit-exactly; compute the negative half by negation.
- Boundary conditions:
  - idx = 2^ADDR_W-1 reads T[2^ADDR_W], the top endpoint; there is no wrap.
  - x = min maps to idx 0, frac 0, giving -(2^(DATA_W-1)-1).
  - hard_thresh = 0 in hard mode outputs 0.
  - in_valid while in_ready=0 is ignored; upstream holds the sample.

Decomposition:
- Package waveshaper_pkg holds:
  - the mode_e enum (MODE_BYPASS, MODE_SOFT, MODE_HARD);
  - the FRAC_W derivation;
  - a saturate function;
  - the tanh table-generation function.
- Sub-module softclip_curve_rom(DATA_W, ADDR_W, CURVE_K): dual-read, combinational, elaboration-generated table. Inputs idx; outputs T[idx] and T[idx+1].

Test Plan:
- Soft mode, gain 0, out_ready=1:
  - in 0 -> out 0
  - in 256 -> 772
  - in 128 -> 386
  - in -256 -> -772
  - each output appears exactly 3 cycles after acceptance.
- Soft extremes: in -32768 -> -32767; in 32767 -> 32766 (32759 + (8*255)>>8).
- Drive: gain_shift 2, in 8192 -> x saturates to 32767, out 32766. gain_shift 7, in -300 -> x = -32768, out -32767.
- Hard mode, hard_thresh 10000: in 20000 -> 10000; in -20000 -> -10000; in 5000 -> 5000. Bypass mode, gain 7: in 1234 -> 1234.
- Backpressure and per-sample mode:
  - Stream 10 samples with alternating modes; hold out_ready=0 for 4 cycles.
  - out_sample and out_valid are stable during the stall and in_ready=0.
  - No sample is lost or duplicated, order is preserved, and each sample uses its own mode.
- Reset and symmetry:
  - Assert rst for 1 cycle with 3 samples in flight: out_valid=0 the next cycle and those samples never appear; after reset out_sample=0 and in_ready=1.
  - Sweep all 2^16 inputs in soft mode against the reference model: every output matches, and output at in is the negation of output at -in wherever in is a table point.
